// File: rtl/tl_ul_mem_responder_if.sv
// Purpose : TileLink-UL A/D channel bundle plus memory-access monitor pulses.
// Latency : none (wiring only).
// Backpressure: A uses a_valid/a_ready and D uses d_valid/d_ready. Monitor pulses cannot be stalled.
// Ports   : master = requester side (drives A, d_ready); slave = responder side (drives a_ready, D, monitor).
interface tl_ul_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int SRC_W  = 4,
    parameter int SIZE_W = 3
);
    localparam int MASK_W = DATA_W / 8;

    logic              a_valid;
    logic              a_ready;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [SIZE_W-1:0] a_size;
    logic [SRC_W-1:0]  a_source;
    logic [ADDR_W-1:0] a_address;
    logic [MASK_W-1:0] a_mask;
    logic [DATA_W-1:0] a_data;

    logic              d_valid;
    logic              d_ready;
    logic [2:0]        d_opcode;
    logic [1:0]        d_param;
    logic [SIZE_W-1:0] d_size;
    logic [SRC_W-1:0]  d_source;
    logic              d_denied;
    logic              d_corrupt;
    logic [DATA_W-1:0] d_data;

    logic              mem_write_valid;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic [MASK_W-1:0] mem_write_mask;
    logic              mem_read_valid;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data,
        output d_ready,
        input  mem_write_valid, mem_write_addr, mem_write_data, mem_write_mask,
        input  mem_read_valid, mem_read_addr, mem_read_data
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data,
        input  d_ready,
        output mem_write_valid, mem_write_addr, mem_write_data, mem_write_mask,
        output mem_read_valid, mem_read_addr, mem_read_data
    );
endinterface

// File: rtl/tl_ul_mem_responder.sv
// Purpose : TileLink-UL responder backed by a byte-masked word memory (Get / PutFull / PutPartial).
// Latency : A fire at edge N -> d_valid from edge N+2; next a_ready at N+3 if d_ready is held high.
// Backpressure: one request in flight; a_ready only in IDLE, and RESP holds D stable until d_ready.
// Ports   : clk, rst (sync, active-high), bus (slave modport: A channel, D channel, memory monitor pulses).
module tl_ul_mem_responder #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int SRC_W     = 4,
    parameter int SIZE_W    = 3,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    tl_ul_mem_responder_if.slave  bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(MASK_W);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state;
    logic [2:0]        opcode_q;
    logic [SIZE_W-1:0] size_q;
    logic [SRC_W-1:0]  source_q;
    logic [ADDR_W-1:0] addr_q;
    logic [MASK_W-1:0] mask_q;
    logic [DATA_W-1:0] data_q;

    logic              d_valid_q;
    logic [2:0]        d_opcode_q;
    logic [SIZE_W-1:0] d_size_q;
    logic [SRC_W-1:0]  d_source_q;
    logic              d_denied_q;
    logic              d_corrupt_q;
    logic [DATA_W-1:0] d_data_q;

    logic              rd_vld_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] rd_data_q;

    // Contents survive reset; the initializer only gives a defined power-on image.
    logic [DATA_W-1:0] mem [MEM_DEPTH] = '{default: '0};

    logic              a_fire;
    logic [IDX_W-1:0]  word_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic [ADDR_W-1:0] align_mask;
    logic [ADDR_W-1:0] word_addr;
    logic              is_get;
    logic              is_put;
    logic              denied;
    logic              do_write;
    logic              do_read;
    logic              unused_ok;

    assign a_fire     = bus.a_valid & bus.a_ready;
    assign word_idx   = addr_q[ADDR_W-1:OFF_W];
    assign mem_idx    = word_idx[MEM_AW-1:0];
    assign word_addr  = {word_idx, {OFF_W{1'b0}}};
    assign align_mask = (ADDR_W'(1) << size_q) - ADDR_W'(1);
    assign is_get     = (opcode_q == OP_GET);
    assign is_put     = (opcode_q == OP_PUT_FULL) || (opcode_q == OP_PUT_PART);

    // Any of these makes the request a no-op that only returns a denied ack.
    assign denied = (word_idx >= IDX_W'(MEM_DEPTH))
                  | (size_q > SIZE_W'(OFF_W))
                  | ((addr_q & align_mask) != '0)
                  | ~(is_get | is_put);

    // Gating with rst keeps an access aborted by reset from touching memory or pulsing the monitor.
    assign do_write = (state == ACCESS) & is_put & ~denied & ~rst;
    assign do_read  = (state == ACCESS) & is_get & ~denied;

    assign bus.a_ready = (state == IDLE) & ~rst;

    assign bus.d_valid   = d_valid_q;
    assign bus.d_opcode  = d_opcode_q;
    assign bus.d_param   = 2'd0;
    assign bus.d_size    = d_size_q;
    assign bus.d_source  = d_source_q;
    assign bus.d_denied  = d_denied_q;
    assign bus.d_corrupt = d_corrupt_q;
    assign bus.d_data    = d_data_q;

    assign bus.mem_write_valid = do_write;
    assign bus.mem_write_addr  = word_addr;
    assign bus.mem_write_data  = data_q;
    assign bus.mem_write_mask  = mask_q;
    assign bus.mem_read_valid  = rd_vld_q;
    assign bus.mem_read_addr   = rd_addr_q;
    assign bus.mem_read_data   = rd_data_q;

    assign unused_ok = ^bus.a_param;

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (mask_q[i]) mem[mem_idx][8*i +: 8] <= data_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            opcode_q    <= '0;
            size_q      <= '0;
            source_q    <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= '0;
            d_size_q    <= '0;
            d_source_q  <= '0;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
            d_data_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            rd_vld_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_fire) begin
                        opcode_q <= bus.a_opcode;
                        size_q   <= bus.a_size;
                        source_q <= bus.a_source;
                        addr_q   <= bus.a_address;
                        mask_q   <= bus.a_mask;
                        data_q   <= bus.a_data;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    d_opcode_q  <= is_get ? OP_ACK_DATA : OP_ACK;
                    d_size_q    <= size_q;
                    d_source_q  <= source_q;
                    d_denied_q  <= denied;
                    d_corrupt_q <= denied & is_get;
                    d_data_q    <= do_read ? mem[mem_idx] : '0;
                    rd_vld_q    <= do_read;
                    rd_addr_q   <= word_addr;
                    rd_data_q   <= do_read ? mem[mem_idx] : '0;
                    state       <= RESP;
                end
                RESP: begin
                    // First RESP cycle raises d_valid; D fields were settled at the ACCESS edge.
                    if (!d_valid_q) begin
                        d_valid_q <= 1'b1;
                    end else if (bus.d_ready) begin
                        d_valid_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Purpose : Self-checking bench for tl_ul_mem_responder (vector table plus multi-cycle sequences).
// Latency : checks d_valid at fire+2 and a_ready at fire+3 with d_ready high.
// Backpressure: exercises d_ready held low, a_valid during RESP, and reset while in RESP.
module tb_tl_ul_mem_responder;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    tl_ul_mem_responder_if #(.ADDR_W(32), .DATA_W(64), .SRC_W(4), .SIZE_W(3)) bus ();

    tl_ul_mem_responder #(
        .ADDR_W(32), .DATA_W(64), .SRC_W(4), .SIZE_W(3), .MEM_DEPTH(1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [3:0]  src;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        logic [2:0]  e_op;
        logic        e_den;
        logic        e_cor;
        logic [63:0] e_data;
        logic        e_wr;
        logic        e_rd;
    } vec_t;

    vec_t vecs [15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_a(input vec_t v);
        bus.a_opcode  = v.op;
        bus.a_param   = 3'd0;
        bus.a_size    = v.size;
        bus.a_source  = v.src;
        bus.a_address = v.addr;
        bus.a_mask    = v.mask;
        bus.a_data    = v.data;
        bus.a_valid   = 1'b1;
    endtask

    // Full transaction with d_ready held high: latency, D fields, monitor pulses.
    task automatic txn(input vec_t v, input string tag);
        int k;
        int wr_cnt;
        int rd_cnt;
        logic [31:0] wr_addr;
        logic [7:0]  wr_mask;
        logic [63:0] wr_data;
        logic [31:0] rd_addr;
        logic [63:0] rd_data;
        wr_cnt = 0; rd_cnt = 0;
        wr_addr = '0; wr_mask = '0; wr_data = '0; rd_addr = '0; rd_data = '0;
        drive_a(v);
        k = 0;
        while (!bus.a_ready && k < 20) begin step(); k++; end
        chk({tag, "_accept"}, bus.a_ready, 1'b1);
        step();
        bus.a_valid = 1'b0;
        k = 0;
        while (k < 20) begin
            if (bus.mem_write_valid) begin
                wr_cnt++; wr_addr = bus.mem_write_addr; wr_mask = bus.mem_write_mask; wr_data = bus.mem_write_data;
            end
            if (bus.mem_read_valid) begin
                rd_cnt++; rd_addr = bus.mem_read_addr; rd_data = bus.mem_read_data;
            end
            if (bus.d_valid) break;
            step();
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'd2);
        chk({tag, "_dopcode"}, bus.d_opcode, v.e_op);
        chk({tag, "_ddenied"}, bus.d_denied, v.e_den);
        chk({tag, "_dcorrupt"}, bus.d_corrupt, v.e_cor);
        chk({tag, "_ddata"}, bus.d_data, v.e_data);
        chk({tag, "_dsource"}, bus.d_source, v.src);
        chk({tag, "_dsize"}, bus.d_size, v.size);
        chk({tag, "_dparam"}, bus.d_param, 2'd0);
        chk({tag, "_wr_pulses"}, 64'(wr_cnt), 64'(v.e_wr));
        chk({tag, "_rd_pulses"}, 64'(rd_cnt), 64'(v.e_rd));
        if (v.e_wr) begin
            chk({tag, "_wr_addr"}, wr_addr, v.addr & 32'hFFFF_FFF8);
            chk({tag, "_wr_mask"}, wr_mask, v.mask);
            chk({tag, "_wr_data"}, wr_data, v.data);
        end
        if (v.e_rd) begin
            chk({tag, "_rd_addr"}, rd_addr, v.addr & 32'hFFFF_FFF8);
            chk({tag, "_rd_data"}, rd_data, v.e_data);
        end
        step();
        chk({tag, "_dvalid_after_fire"}, bus.d_valid, 1'b0);
        chk({tag, "_aready_after_fire"}, bus.a_ready, 1'b1);
    endtask

    initial begin
        vec_t v;
        vec_t w;
        logic [2:0]  s_op;
        logic [63:0] s_data;
        logic [3:0]  s_src;
        logic        stable_ok;
        int k;

        checks = 0;
        failures = 0;

        //          op    size  src    addr           mask   data                    e_op  den   cor   e_data                  wr    rd
        vecs[0]  = '{3'd0, 3'd3, 4'd3, 32'h0000_0040, 8'hFF, 64'h1122334455667788, 3'd0, 1'b0, 1'b0, 64'h0,                1'b1, 1'b0};
        vecs[1]  = '{3'd4, 3'd3, 4'd5, 32'h0000_0040, 8'hFF, 64'h0,                3'd1, 1'b0, 1'b0, 64'h1122334455667788, 1'b0, 1'b1};
        vecs[2]  = '{3'd1, 3'd3, 4'd1, 32'h0000_0040, 8'h0F, 64'hAAAAAAAABBBBBBBB, 3'd0, 1'b0, 1'b0, 64'h0,                1'b1, 1'b0};
        vecs[3]  = '{3'd4, 3'd3, 4'd2, 32'h0000_0040, 8'h00, 64'h0,                3'd1, 1'b0, 1'b0, 64'h11223344BBBBBBBB, 1'b0, 1'b1};
        vecs[4]  = '{3'd4, 3'd3, 4'd7, 32'h0000_2000, 8'hFF, 64'h0,                3'd1, 1'b1, 1'b1, 64'h0,                1'b0, 1'b0};
        vecs[5]  = '{3'd4, 3'd2, 4'd4, 32'h0000_0042, 8'h0F, 64'h0,                3'd1, 1'b1, 1'b1, 64'h0,                1'b0, 1'b0};
        vecs[6]  = '{3'd6, 3'd3, 4'd6, 32'h0000_0048, 8'hFF, 64'h0,                3'd0, 1'b1, 1'b0, 64'h0,                1'b0, 1'b0};
        vecs[7]  = '{3'd0, 3'd4, 4'd8, 32'h0000_0050, 8'hFF, 64'hDEADBEEFDEADBEEF, 3'd0, 1'b1, 1'b0, 64'h0,                1'b0, 1'b0};
        vecs[8]  = '{3'd1, 3'd3, 4'd9, 32'h0000_1FF8, 8'h80, 64'hCCDDEEFF00112233, 3'd0, 1'b0, 1'b0, 64'h0,                1'b1, 1'b0};
        vecs[9]  = '{3'd4, 3'd3, 4'd10, 32'h0000_1FF8, 8'hFF, 64'h0,               3'd1, 1'b0, 1'b0, 64'hCC00000000000000, 1'b0, 1'b1};
        vecs[10] = '{3'd4, 3'd2, 4'd11, 32'h0000_0044, 8'hF0, 64'h0,               3'd1, 1'b0, 1'b0, 64'h11223344BBBBBBBB, 1'b0, 1'b1};
        vecs[11] = '{3'd0, 3'd3, 4'd12, 32'h0000_2000, 8'hFF, 64'h0123456789ABCDEF, 3'd0, 1'b1, 1'b0, 64'h0,               1'b0, 1'b0};
        vecs[12] = '{3'd1, 3'd1, 4'd13, 32'h0000_0049, 8'h06, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b1, 1'b0, 64'h0,               1'b0, 1'b0};
        vecs[13] = '{3'd4, 3'd3, 4'd14, 32'h0000_0048, 8'hFF, 64'h0,               3'd1, 1'b0, 1'b0, 64'h0,                1'b0, 1'b1};
        vecs[14] = '{3'd4, 3'd3, 4'd15, 32'h0000_0050, 8'hFF, 64'h0,               3'd1, 1'b0, 1'b0, 64'h0,                1'b0, 1'b1};

        bus.a_valid = 1'b0; bus.a_opcode = '0; bus.a_param = '0; bus.a_size = '0;
        bus.a_source = '0; bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0;
        bus.d_ready = 1'b1;
        rst = 1'b1;

        // Reset state
        step(); step();
        chk("rst_aready", bus.a_ready, 1'b0);
        chk("rst_dvalid", bus.d_valid, 1'b0);
        chk("rst_ddenied", bus.d_denied, 1'b0);
        chk("rst_dcorrupt", bus.d_corrupt, 1'b0);
        chk("rst_ddata", bus.d_data, 64'h0);
        chk("rst_dopcode", bus.d_opcode, 3'd0);
        chk("rst_wr_pulse", bus.mem_write_valid, 1'b0);
        chk("rst_rd_pulse", bus.mem_read_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_aready", bus.a_ready, 1'b1);

        // Vector table
        for (int i = 0; i < 15; i++) begin
            txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: d_ready low for 5 cycles, a second request waits on A meanwhile.
        bus.d_ready = 1'b0;
        v = vecs[3];
        v.src = 4'd6;
        drive_a(v);
        step();
        bus.a_valid = 1'b0;
        k = 0;
        while (!bus.d_valid && k < 20) begin step(); k++; end
        chk("bp_dvalid", bus.d_valid, 1'b1);
        s_op = bus.d_opcode; s_data = bus.d_data; s_src = bus.d_source;
        chk("bp_data", s_data, 64'h11223344BBBBBBBB);
        w = vecs[9];
        drive_a(w);
        stable_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (!bus.d_valid || bus.a_ready || bus.d_opcode !== s_op || bus.d_data !== s_data || bus.d_source !== s_src)
                stable_ok = 1'b0;
        end
        chk("bp_hold_stable", stable_ok, 1'b1);
        chk("bp_aready_low", bus.a_ready, 1'b0);
        bus.d_ready = 1'b1;
        step();
        chk("bp_dvalid_drop", bus.d_valid, 1'b0);
        chk("bp_aready_after_fire", bus.a_ready, 1'b1);
        step();
        bus.a_valid = 1'b0;
        chk("bp_second_accepted", bus.a_ready, 1'b0);
        k = 0;
        while (!bus.d_valid && k < 20) begin step(); k++; end
        chk("bp_second_latency", 64'(k), 64'd2);
        chk("bp_second_data", bus.d_data, 64'hCC00000000000000);
        chk("bp_second_src", bus.d_source, 4'd10);
        step();

        // Reset while in RESP: response is dropped, the write is kept.
        bus.d_ready = 1'b0;
        v = '{3'd0, 3'd3, 4'd2, 32'h0000_0080, 8'hFF, 64'h5555AAAA5555AAAA, 3'd0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
        drive_a(v);
        k = 0;
        while (!bus.a_ready && k < 20) begin step(); k++; end
        step();
        bus.a_valid = 1'b0;
        k = 0;
        while (!bus.d_valid && k < 20) begin step(); k++; end
        chk("rr_dvalid_before_rst", bus.d_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_dvalid_dropped", bus.d_valid, 1'b0);
        bus.d_ready = 1'b1;
        stable_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bus.d_valid) stable_ok = 1'b0;
            step();
        end
        chk("rr_no_response", stable_ok, 1'b1);
        chk("rr_aready", bus.a_ready, 1'b1);
        v = '{3'd4, 3'd3, 4'd1, 32'h0000_0080, 8'hFF, 64'h0, 3'd1, 1'b0, 1'b0, 64'h5555AAAA5555AAAA, 1'b0, 1'b1};
        txn(v, "rr_get");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tl_ul_mem_responder.md
TL_UL_MEM_RESPONDER -- requirements
Module: tl_ul_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width; DATA_W/8 byte lanes.
REQ-003 SHALL have parameter SRC_W, default 4, source ID width.
REQ-004 SHALL have parameter SIZE_W, default 3, log2 transfer-size width.
REQ-005 SHALL have parameter MEM_DEPTH, default 1024, backing store depth in DATA_W words.
REQ-006 Ports SHALL be: clk in 1, sole clock; rst in 1, reset.
REQ-007 Reset SHALL be synchronous and active-high; one clock only.
REQ-008 Ports SHALL be: a_valid in 1; a_ready out 1; a_opcode in 3; a_param in 3 (ignored); a_size in SIZE_W; a_source in SRC_W; a_address in ADDR_W; a_mask in DATA_W/8; a_data in DATA_W.
REQ-009 Ports SHALL be: d_valid out 1; d_ready in 1; d_opcode out 3; d_param out 2 (always 0); d_size out SIZE_W; d_source out SRC_W; d_denied out 1; d_corrupt out 1; d_data out DATA_W.
REQ-010 Ports SHALL be: mem_write_valid out 1; mem_write_addr out ADDR_W; mem_write_data out DATA_W; mem_write_mask out DATA_W/8; mem_read_valid out 1; mem_read_addr out ADDR_W; mem_read_data out DATA_W; single-cycle monitor pulses.

Function
REQ-011 SHALL be a TileLink-UL responder: accept Get (4), PutFullData (0), PutPartialData (1); reply AccessAckData (1) to Get and AccessAck (0) to puts.
REQ-012 FSM SHALL have states IDLE, ACCESS, RESP; a_ready = 1 only in IDLE.
REQ-013 A fire (a_valid & a_ready) SHALL register opcode, size, source, address, mask and data, then go IDLE->ACCESS.
REQ-014 ACCESS SHALL last exactly one cycle, perform the memory operation and go to RESP.
REQ-015 RESP SHALL hold d_valid=1 with stable fields until d_ready; on d fire go to IDLE.
REQ-016 Latency: A fire at edge N SHALL give d_valid=1 from edge N+2; with d_ready held high, next a_ready at N+3.
REQ-017 Word index SHALL be a_address[ADDR_W-1:3] (for DATA_W=64); low bits select lanes only.
REQ-018 Put SHALL write only bytes whose a_mask bit is 1; other bytes are unchanged.
REQ-019 Get SHALL return the full addressed word on d_data regardless of mask.
REQ-020 Error: word index >= MEM_DEPTH, a_size > log2(DATA_W/8), address not aligned to 2^a_size, or unsupported opcode SHALL set d_denied=1.
REQ-021 A denied request SHALL perform no memory access and assert no monitor pulse.
REQ-022 Denied Get SHALL return AccessAckData with d_corrupt=1 and d_data=0.
REQ-023 Denied Put or unsupported opcode SHALL return AccessAck with d_corrupt=0.
REQ-024 d_size and d_source SHALL echo the request.
REQ-025 d_data SHALL be 0 for AccessAck.
REQ-026 mem_write_valid SHALL pulse 1 cycle at ACCESS for a non-denied put, with word-aligned addr, data and mask.
REQ-027 mem_read_valid SHALL pulse 1 cycle when read data is captured for a non-denied Get, with addr and data.
REQ-028 a_valid during ACCESS/RESP SHALL be ignored; that request is accepted in IDLE.
REQ-029 d_ready asserted before d_valid SHALL have no effect.

Reset
REQ-030 rst SHALL force IDLE; a_ready=0 during reset and 1 on the first cycle after; d_valid, d_denied, d_corrupt and monitor pulses 0; registered d fields 0.
REQ-031 rst in ACCESS or RESP SHALL abort: no response is issued; a write committed before the rst edge stays in memory.
REQ-032 Memory contents SHALL NOT be cleared by reset and SHALL be zero at time 0 in simulation.

Verification
REQ-033 PutFull addr 0x40, data 0x1122334455667788, mask 0xFF, source 3 -> AccessAck src 3, denied 0 at N+2; Get 0x40 -> AccessAckData 0x1122334455667788.
REQ-034 PutPartial 0x40, mask 0x0F, data 0xAAAAAAAABBBBBBBB -> next Get returns 0x11223344BBBBBBBB.
REQ-035 Get 0x2000 (index 1024) -> d_denied=1, d_corrupt=1, d_data=0, mem_read_valid never pulses.
REQ-036 Get size 2 at 0x42 (misaligned) -> denied; opcode 6 -> AccessAck denied.
REQ-037 d_ready held low 5 cycles -> d fields stable, a_ready=0 throughout; new A accepted the cycle after d fire.
REQ-038 rst in RESP -> d_valid drops next cycle, no response; later Get returns the written data.
